// File: rtl/axi_scratchpad_slave.sv
// rtl/axi_scratchpad_slave.sv - AXI4 slave backed by a word-addressed scratchpad
module axi_scratchpad_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] WIN_END =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Word index inside the window; bits above the window alias (INCR wraps).
  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  // Address of the following beat for FIXED / INCR / WRAP.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst,
                                                      input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = a + ADDR_WIDTH'(BYTES);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFF_W) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  // Response code decided once per burst at the address handshake.
  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (a < BASE_ADDR || {1'b0, a} >= WIN_END)
      return RESP_DECERR;
    if (size != 3'(OFF_W) || burst == 2'b11 || (burst == 2'b10 && !wrap_ok))
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // ---------------- write side ----------------
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [1:0]            w_burst;
  logic [1:0]            w_err;
  logic [7:0]            w_cnt;
  logic                  w_bad_last;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] aw_aligned;

  assign w_fire     = s_axi_wvalid & s_axi_wready;
  assign aw_aligned = {s_axi_awaddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Write FSM: accept AW, count W beats, track wlast agreement, issue B.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_burst       <= '0;
      w_err         <= RESP_OKAY;
      w_cnt         <= '0;
      w_bad_last    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_addr        <= aw_aligned;
            w_len         <= s_axi_awlen;
            w_burst       <= s_axi_awburst;
            w_err         <= decode(aw_aligned, s_axi_awlen, s_axi_awsize, s_axi_awburst);
            w_cnt         <= '0;
            w_bad_last    <= 1'b0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_burst, w_len);
            w_cnt  <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              if (w_err != RESP_OKAY)
                s_axi_bresp <= w_err;
              else if (w_bad_last || !s_axi_wlast)
                s_axi_bresp <= RESP_SLVERR;
              else
                s_axi_bresp <= RESP_OKAY;
              w_state <= W_RESP;
            end else if (s_axi_wlast) begin
              w_bad_last <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane commit of accepted beats; errored bursts never touch memory.
  always_ff @(posedge clock_i) begin
    if (w_fire && w_err == RESP_OKAY) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b])
          mem[to_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] ar_aligned;
  logic [1:0]            ar_err;

  assign ar_aligned = {s_axi_araddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign ar_err     = decode(ar_aligned, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign r_next     = next_addr(r_addr, r_burst, r_len);

  // Read FSM: prefetch each beat into registered rdata, advance on R handshake.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_burst       <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= ar_err;
            s_axi_rdata   <= (ar_err != RESP_OKAY) ? '0 : mem[to_idx(ar_aligned)];
            r_addr        <= ar_aligned;
            r_len         <= s_axi_arlen;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= (r_cnt + 8'd1 == r_len);
              s_axi_rdata <= (s_axi_rresp != RESP_OKAY) ? '0 : mem[to_idx(r_next)];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0],
                           s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// tb/tb_axi_scratchpad_slave.sv - directed self-checking bench for axi_scratchpad_slave
module tb_axi_scratchpad_slave;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [1:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [1:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [1:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic [1:0]  resp;

  always #5 clk = ~clk;

  axi_scratchpad_slave dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .s_axi_awid     (s_axi_awid),
    .s_axi_awaddr   (s_axi_awaddr),
    .s_axi_awlen    (s_axi_awlen),
    .s_axi_awsize   (s_axi_awsize),
    .s_axi_awburst  (s_axi_awburst),
    .s_axi_awlock   (1'b0),
    .s_axi_awcache  (4'h0),
    .s_axi_awprot   (3'h0),
    .s_axi_awqos    (4'h0),
    .s_axi_awregion (4'h0),
    .s_axi_awvalid  (s_axi_awvalid),
    .s_axi_awready  (s_axi_awready),
    .s_axi_wdata    (s_axi_wdata),
    .s_axi_wstrb    (s_axi_wstrb),
    .s_axi_wlast    (s_axi_wlast),
    .s_axi_wvalid   (s_axi_wvalid),
    .s_axi_wready   (s_axi_wready),
    .s_axi_bid      (s_axi_bid),
    .s_axi_bresp    (s_axi_bresp),
    .s_axi_bvalid   (s_axi_bvalid),
    .s_axi_bready   (s_axi_bready),
    .s_axi_arid     (s_axi_arid),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arlen    (s_axi_arlen),
    .s_axi_arsize   (s_axi_arsize),
    .s_axi_arburst  (s_axi_arburst),
    .s_axi_arlock   (1'b0),
    .s_axi_arcache  (4'h0),
    .s_axi_arprot   (3'h0),
    .s_axi_arqos    (4'h0),
    .s_axi_arregion (4'h0),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_rid      (s_axi_rid),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rlast    (s_axi_rlast),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write burst from wbuf/sbuf; last_at<0 means wlast on the counted final beat.
  task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int last_at, input bit gaps,
                          output logic [1:0] bresp);
    int t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len[7:0];
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_accept", 32'(s_axi_awready), 32'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk("wready_after_aw", 32'(s_axi_wready), 32'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        s_axi_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i];
      s_axi_wlast = (last_at < 0) ? (i == len) : (i == last_at);
      s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 50) begin @(negedge clk); t++; end
      chk($sformatf("w_accept[%0d]", i), 32'(s_axi_wready), 32'd1);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("bvalid_after_last", 32'(s_axi_bvalid), 32'd1);
    chk("wready_after_last", 32'(s_axi_wready), 32'd0);
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge clk); t++; end
    chk("bid", 32'(s_axi_bid), 32'(id));
    bresp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("awready_after_b", 32'(s_axi_awready), 32'd1);
  endtask

  // One read burst into rbuf/rrbuf, checking rid/rlast per beat and stall stability.
  task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input bit gaps);
    int t;
    int g;
    logic [31:0] snap;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len[7:0];
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_accept", 32'(s_axi_arready), 32'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("rvalid_after_ar", 32'(s_axi_rvalid), 32'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        s_axi_rready = 1'b0;
        g = $urandom_range(0, 2);
        snap = s_axi_rdata;
        repeat (g) begin
          @(negedge clk);
          chk("r_hold_data", s_axi_rdata, snap);
          chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
        end
      end
      s_axi_rready = 1'b1;
      t = 0;
      while (!s_axi_rvalid && t < 50) begin @(negedge clk); t++; end
      rbuf[i] = s_axi_rdata; rrbuf[i] = s_axi_rresp;
      chk($sformatf("rid[%0d]", i), 32'(s_axi_rid), 32'(id));
      chk($sformatf("rlast[%0d]", i), 32'(s_axi_rlast), 32'(i == len));
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
    chk("arready_after_last", 32'(s_axi_arready), 32'd1);
    chk("rvalid_after_last", 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_rlast", 32'(s_axi_rlast), 32'd0);
    chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    chk("rst_ids", 32'({s_axi_bid, s_axi_rid}), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("awready_after_release", 32'(s_axi_awready), 32'd1);
    chk("arready_after_release", 32'(s_axi_arready), 32'd1);

    // INCR write/read, id 2
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(2'b10, 32'h10, 3, 2'b01, -1, 1'b0, resp);
    chk("incr_bresp", 32'(resp), 32'd0);
    do_read(2'b10, 32'h10, 3, 2'b01, 1'b0);
    chk("incr_r0", rbuf[0], 32'h000000A0);
    chk("incr_r1", rbuf[1], 32'h000000A1);
    chk("incr_r2", rbuf[2], 32'h000000A2);
    chk("incr_r3", rbuf[3], 32'h000000A3);
    chk("incr_rresp", 32'({rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]}), 32'd0);

    // strobe merge
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    do_write(2'b00, 32'h0, 0, 2'b01, -1, 1'b0, resp);
    wbuf[0] = 32'h1234_5678; sbuf[0] = 4'b0101;
    do_write(2'b00, 32'h0, 0, 2'b01, -1, 1'b0, resp);
    do_read(2'b00, 32'h0, 0, 2'b01, 1'b0);
    chk("strobe_merge", rbuf[0], 32'hFF34_FF78);

    // WRAP len 3 at 0x18
    do_read(2'b01, 32'h18, 3, 2'b10, 1'b0);
    chk("wrap_b0", rbuf[0], 32'h000000A2);
    chk("wrap_b1", rbuf[1], 32'h000000A3);
    chk("wrap_b2", rbuf[2], 32'h000000A0);
    chk("wrap_b3", rbuf[3], 32'h000000A1);

    // INCR alias past the top of the window
    wbuf[0] = 32'hC0FF_EE00; sbuf[0] = 4'hF;
    do_write(2'b00, 32'h3FC, 0, 2'b01, -1, 1'b0, resp);
    do_read(2'b00, 32'h3FC, 1, 2'b01, 1'b0);
    chk("alias_b0", rbuf[0], 32'hC0FF_EE00);
    chk("alias_b1", rbuf[1], 32'hFF34_FF78);
    chk("alias_rresp", 32'(rrbuf[1]), 32'd0);

    // DECERR read just past the window
    do_read(2'b11, 32'h400, 0, 2'b01, 1'b0);
    chk("decerr_rresp", 32'(rrbuf[0]), 32'd3);
    chk("decerr_rdata", rbuf[0], 32'd0);

    // SLVERR write (reserved burst) leaves memory alone
    wbuf[0] = 32'hDEAD_BEEF; sbuf[0] = 4'hF;
    do_write(2'b01, 32'h10, 0, 2'b11, -1, 1'b0, resp);
    chk("slverr_bresp", 32'(resp), 32'd2);
    do_read(2'b00, 32'h10, 0, 2'b01, 1'b0);
    chk("slverr_mem_kept", rbuf[0], 32'h000000A0);

    // early wlast: three beats still consumed and written, bresp SLVERR
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2;
    sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
    do_write(2'b00, 32'h20, 2, 2'b01, 1, 1'b0, resp);
    chk("early_wlast_bresp", 32'(resp), 32'd2);
    do_read(2'b00, 32'h20, 2, 2'b01, 1'b0);
    chk("early_wlast_d0", rbuf[0], 32'hB0);
    chk("early_wlast_d1", rbuf[1], 32'hB1);
    chk("early_wlast_d2", rbuf[2], 32'hB2);

    // backpressure on len 15 bursts
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h100 + 32'(i); sbuf[i] = 4'hF; end
    do_write(2'b01, 32'h40, 15, 2'b01, -1, 1'b1, resp);
    chk("bp_bresp", 32'(resp), 32'd0);
    do_read(2'b01, 32'h40, 15, 2'b01, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_beat[%0d]", i), rbuf[i], 32'h100 + 32'(i));
      chk($sformatf("bp_rresp[%0d]", i), 32'(rrbuf[i]), 32'd0);
    end

    // concurrent write/read collision on idx 0x80/4
    wbuf[0] = 32'h1111_1111; sbuf[0] = 4'hF;
    do_write(2'b00, 32'h80, 0, 2'b01, -1, 1'b0, resp);
    s_axi_arid = 2'b01; s_axi_araddr = 32'h80; s_axi_arlen = 8'd3;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b00; s_axi_arvalid = 1'b1;
    s_axi_awid = 2'b01; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    chk("col_beat0", s_axi_rdata, 32'h1111_1111);
    s_axi_wdata = 32'h2222_2222; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    chk("col_beat1_old", s_axi_rdata, 32'h1111_1111);
    chk("col_bvalid", 32'(s_axi_bvalid), 32'd1);
    @(negedge clk);
    chk("col_beat2_new", s_axi_rdata, 32'h2222_2222);
    @(negedge clk);
    chk("col_beat3_new", s_axi_rdata, 32'h2222_2222);
    chk("col_beat3_rlast", 32'(s_axi_rlast), 32'd1);
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk("col_rdone", 32'(s_axi_rvalid), 32'd0);
    chk("col_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;

    // reset pulsed mid-read
    s_axi_arid = 2'b00; s_axi_araddr = 32'h40; s_axi_arlen = 8'd15;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_read_rvalid", 32'(s_axi_rvalid), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("async_rst_arready", 32'(s_axi_arready), 32'd0);
    @(negedge clk);
    s_axi_rready = 1'b0;
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", 32'(s_axi_arready), 32'd1);
    chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
    do_read(2'b00, 32'h40, 0, 2'b01, 1'b0);
    chk("post_rst_mem_kept", rbuf[0], 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
